// File: rtl/int_div_iterative.sv
// Iterative unsigned integer divider behind a val/rdy request/response interface.
// A restoring shift-subtract datapath runs one quotient bit per cycle for nbits
// cycles. It returns {quotient, remainder}. Dividing by zero is not special-cased.
// The datapath yields quotient = all ones and remainder = dividend for that case.
module int_div_iterative #(
  parameter int unsigned nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic [2*nbits-1:0] req_msg,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic [2*nbits-1:0] resp_msg
);

  localparam int unsigned CW = (nbits > 1) ? $clog2(nbits) : 1;
  localparam int unsigned RW = nbits + 1;   // trial remainder width
  localparam int unsigned SW = nbits + 2;   // shifted remainder plus sign headroom

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic          req_rdy_d;
  logic          resp_val_d;

  logic [RW-1:0]    rem_q;
  logic [nbits-1:0] quo_q;
  logic [nbits-1:0] dvsr_q;
  logic [CW-1:0]    count_q;

  logic [SW-1:0]    rem_sh_c;
  logic [SW-1:0]    diff_c;
  logic             diff_neg_c;
  logic             accept_c;
  logic             last_iter_c;

  // Restoring-division step: shift {rem, quo} left by one and trial-subtract the divisor.
  // The extra top bit keeps the sign exact even when operand MSBs are set.
  always_comb begin
    rem_sh_c   = {rem_q, quo_q[nbits-1]};
    diff_c     = rem_sh_c - {2'b00, dvsr_q};
    diff_neg_c = diff_c[SW-1];
  end

  // Handshake and iteration-end decode.
  always_comb begin
    accept_c    = (state_q == IDLE) && req_val && req_rdy;
    last_iter_c = (count_q == CW'(nbits - 1));
  end

  // FSM state and registered-output register. Reset clears every output immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      req_rdy  <= 1'b0;
      resp_val <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_rdy  <= req_rdy_d;
      resp_val <= resp_val_d;
    end
  end

  // Next-state logic. The outputs follow the state being entered.
  always_comb begin
    state_d    = state_q;
    req_rdy_d  = 1'b0;
    resp_val_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = CALC;
        end
      end
      CALC: begin
        if (last_iter_c) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (resp_rdy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    req_rdy_d  = (state_d == IDLE);
    resp_val_d = (state_d == DONE);
  end

  // Datapath registers: load on accept, iterate in CALC, hold otherwise.
  // Holding keeps resp_msg stable through DONE stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      count_q <= '0;
    end else if (accept_c) begin
      rem_q   <= '0;
      quo_q   <= req_msg[2*nbits-1:nbits];
      dvsr_q  <= req_msg[nbits-1:0];
      count_q <= '0;
    end else if (state_q == CALC) begin
      if (!diff_neg_c) begin
        rem_q <= diff_c[RW-1:0];
        quo_q <= {quo_q[nbits-2:0], 1'b1};
      end else begin
        rem_q <= rem_sh_c[RW-1:0];
        quo_q <= {quo_q[nbits-2:0], 1'b0};
      end
      count_q <= count_q + CW'(1);
    end
  end

  // The response is a direct view of the quotient/remainder registers.
  assign resp_msg = {quo_q, rem_q[nbits-1:0]};

endmodule

// File: tb/tb_int_div_iterative.sv
// Self-checking bench for int_div_iterative.
// Responses are compared against a plain-arithmetic divide model.
module tb_int_div_iterative;

  localparam int unsigned N = 32;

  logic          clk;
  logic          reset;
  logic          req_val;
  logic          req_rdy;
  logic [2*N-1:0] req_msg;
  logic          resp_val;
  logic          resp_rdy;
  logic [2*N-1:0] resp_msg;

  int checks;
  int errors;
  int cyc;

  logic [2*N-1:0] exp_q[$];

  int_div_iterative #(.nbits(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .req_msg  (req_msg),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy),
    .resp_msg (resp_msg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Golden model: {quotient, remainder}. Dividing by zero gives all ones and the dividend.
  function automatic logic [2*N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
    if (b == '0) return {{N{1'b1}}, a};
    return {a / b, a % b};
  endfunction

  // Issue one request from IDLE and wait until resp_val rises.
  // lat counts rising edges from the accepting edge to the first cycle with resp_val high.
  task automatic run_req(input logic [N-1:0] a, input logic [N-1:0] b, input logic rdy_early,
                         output logic [2*N-1:0] msg, output int lat, output bit to);
    int w;
    to  = 1'b0;
    lat = 0;
    msg = '0;
    @(negedge clk);
    req_val  = 1'b1;
    req_msg  = {a, b};
    resp_rdy = rdy_early;
    w = 0;
    while (!req_rdy && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!req_rdy) begin
      to = 1'b1;
      req_val = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_val = 1'b0;
    req_msg = {$urandom, $urandom};
    while (!resp_val && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!resp_val) to = 1'b1;
    msg = resp_msg;
  endtask

  // Complete the response handshake on the next edge.
  task automatic take_resp();
    resp_rdy = 1'b1;
    @(posedge clk);
    #1;
    resp_rdy = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    req_val  = 1'b0;
    resp_rdy = 1'b0;
    req_msg  = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({req_rdy, resp_val, resp_msg} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b val=%b msg=%h want all zero", req_rdy, resp_val, resp_msg);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (req_rdy !== 1'b1 || resp_val !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got rdy=%b val=%b want rdy=1 val=0", req_rdy, resp_val);
    end
  endtask

  task automatic test_basic();
    logic [2*N-1:0] msg;
    int lat;
    bit to;
    run_req(32'd100, 32'd7, 1'b1, msg, lat, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL basic_timeout got no response want response");
    end
    checks++;
    if (lat !== int'(N)) begin
      errors++;
      $display("FAIL basic_latency got %0d edges want %0d", lat, N);
    end
    checks++;
    if (msg !== {32'd14, 32'd2}) begin
      errors++;
      $display("FAIL basic_msg got %h want %h", msg, {32'd14, 32'd2});
    end
    take_resp();
    checks++;
    if (resp_val !== 1'b0 || req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL basic_return_idle got val=%b rdy=%b want val=0 rdy=1", resp_val, req_rdy);
    end
  endtask

  task automatic test_corners();
    logic [N-1:0]   ta[6];
    logic [N-1:0]   tb_d[6];
    logic [2*N-1:0] te[6];
    logic [2*N-1:0] msg;
    int lat;
    bit to;
    ta[0] = 32'hFFFF_FFFF; tb_d[0] = 32'd1;          te[0] = {32'hFFFF_FFFF, 32'd0};
    ta[1] = 32'h8000_0000; tb_d[1] = 32'hFFFF_FFFF;  te[1] = {32'd0, 32'h8000_0000};
    ta[2] = 32'd12345;     tb_d[2] = 32'd0;          te[2] = {32'hFFFF_FFFF, 32'd12345};
    ta[3] = 32'd3;         tb_d[3] = 32'd10;         te[3] = {32'd0, 32'd3};
    ta[4] = 32'hDEAD_BEEF; tb_d[4] = 32'hDEAD_BEEF;  te[4] = {32'd1, 32'd0};
    ta[5] = 32'd0;         tb_d[5] = 32'd0;          te[5] = {32'hFFFF_FFFF, 32'd0};
    for (int i = 0; i < 6; i++) begin
      run_req(ta[i], tb_d[i], 1'b0, msg, lat, to);
      checks++;
      if (to || msg !== te[i] || lat !== int'(N)) begin
        errors++;
        $display("FAIL corner_%0d got msg=%h lat=%0d to=%b want msg=%h lat=%0d", i, msg, lat, to, te[i], N);
      end
      take_resp();
    end
  endtask

  task automatic test_random();
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2*N-1:0] msg;
    int lat;
    bit to;
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = N'($urandom_range(1, 15));
        1: b = $urandom | 32'h8000_0000;
        2: b = N'($urandom_range(0, 1));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run_req(a, b, 1'($urandom_range(0, 1)), msg, lat, to);
      checks++;
      if (to || msg !== model(a, b)) begin
        errors++;
        $display("FAIL random_%0d a=%h b=%h got %h want %h", i, a, b, msg, model(a, b));
      end
      take_resp();
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2*N-1:0] msg;
    int lat;
    bit to;
    a = $urandom;
    b = $urandom >> 20;
    run_req(a, b, 1'b0, msg, lat, to);
    checks++;
    if (to || msg !== model(a, b)) begin
      errors++;
      $display("FAIL stall_first got %h want %h", msg, model(a, b));
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({resp_val, req_rdy, resp_msg} !== {1'b1, 1'b0, model(a, b)}) begin
        errors++;
        $display("FAIL stall_hold_%0d got val=%b rdy=%b msg=%h want val=1 rdy=0 msg=%h",
                 i, resp_val, req_rdy, resp_msg, model(a, b));
      end
    end
    take_resp();
    checks++;
    if (resp_val !== 1'b0 || req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL stall_release got val=%b rdy=%b want val=0 rdy=1", resp_val, req_rdy);
    end
  endtask

  task automatic test_back_to_back();
    int last_acc;
    int got;
    int cy;
    exp_q.delete();
    got = 0;
    cy  = 0;
    last_acc = 0;
    fork
      begin : producer
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic rdy_s;
        bit acc;
        int w;
        for (int i = 0; i < 50; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          @(negedge clk);
          a = $urandom;
          b = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
          req_val = 1'b1;
          req_msg = {a, b};
          acc = 1'b0;
          w = 0;
          while (!acc && w < 400) begin
            rdy_s = req_rdy;
            @(posedge clk);
            if (rdy_s) acc = 1'b1;
            else begin
              @(negedge clk);
              w++;
            end
          end
          #1;
          req_val = 1'b0;
          if (!acc) begin
            checks++;
            errors++;
            $display("FAIL b2b_accept_timeout req %0d got no accept want accept", i);
            break;
          end
          exp_q.push_back(model(a, b));
          if (i > 0) begin
            checks++;
            if (cyc - last_acc < int'(N) + 2) begin
              errors++;
              $display("FAIL b2b_spacing req %0d got %0d cycles want >= %0d", i, cyc - last_acc, N + 2);
            end
          end
          last_acc = cyc;
        end
      end
      begin : consumer
        logic [2*N-1:0] e;
        while (got < 50 && cy < 20000) begin
          @(negedge clk);
          cy++;
          resp_rdy = ($urandom_range(0, 3) != 0);
          if (resp_val && resp_rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL b2b_unexpected got %h want no response", resp_msg);
            end else begin
              e = exp_q.pop_front();
              if (resp_msg !== e) begin
                errors++;
                $display("FAIL b2b_resp_%0d got %h want %h", got, resp_msg, e);
              end
            end
            got++;
          end
        end
        if (got < 50) begin
          checks++;
          errors++;
          $display("FAIL b2b_timeout got %0d responses want 50", got);
        end
      end
    join
    @(posedge clk);
    #1;
    resp_rdy = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [2*N-1:0] msg;
    int lat;
    bit to;
    int stale;
    @(negedge clk);
    req_val = 1'b1;
    req_msg = {32'hFFFF_0000, 32'd3};
    @(posedge clk);
    #1;
    req_val = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if ({req_rdy, resp_val, resp_msg} !== '0) begin
      errors++;
      $display("FAIL areset_immediate got rdy=%b val=%b msg=%h want all zero", req_rdy, resp_val, resp_msg);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (resp_val) stale++;
    end
    checks++;
    if (stale != 0 || req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL areset_stale got %0d stale cycles rdy=%b want 0 stale rdy=1", stale, req_rdy);
    end
    run_req(32'd50, 32'd5, 1'b0, msg, lat, to);
    checks++;
    if (to || msg !== {32'd10, 32'd0} || lat !== int'(N)) begin
      errors++;
      $display("FAIL areset_next got msg=%h lat=%0d want msg=%h lat=%0d", msg, lat, {32'd10, 32'd0}, N);
    end
    take_resp();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
